itcm_auto_load_ctrl: RTL and testbench

ITCM_AUTO_LOAD_CTRL -- requirements
Module: itcm_auto_load_ctrl

---
 rtl/itcm_auto_load_ctrl.sv | 101 ++++++++++
 tb/tb_itcm_auto_load_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/itcm_auto_load_ctrl.sv
// itcm_auto_load_ctrl: copies LOAD_WORDS words from the load bus into ITCM after load_start.
// Optional XOR checksum check is enabled by defining KRV_ITCM_LOAD_CSUM_EN.
module itcm_auto_load_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LOAD_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] SRC_BASE  = '0,
  parameter logic [ADDR_WIDTH-1:0] ITCM_BASE = '0
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  load_start,
  output logic                  itcm_auto_load,
  output logic                  load_done,
  output logic                  ld_req,
  output logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic                  ld_ack,
  input  logic [DATA_WIDTH-1:0] ld_rdata,
  input  logic                  ld_rvalid,
  output logic                  itcm_wr_en,
  output logic [ADDR_WIDTH-1:0] itcm_wr_addr,
  output logic [DATA_WIDTH-1:0] itcm_wr_data
`ifdef KRV_ITCM_LOAD_CSUM_EN
  ,
  input  logic [DATA_WIDTH-1:0] exp_csum,
  output logic                  load_err
`endif
);
  localparam int CW = $clog2(LOAD_WORDS + 1);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic start, last;
  assign start = load_start && (state_q == IDLE || state_q == DONE);
  assign last  = cnt_q == CW'(LOAD_WORDS - 1);
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = start ? REQ : state_q;
        cnt_d   = start ? '0 : cnt_q;
      end
      REQ: begin
        state_d = !ld_ack ? REQ : ld_rvalid ? WRITE : WAIT;
        data_d  = (ld_ack && ld_rvalid) ? ld_rdata : data_q;
      end
      WAIT: begin
        state_d = ld_rvalid ? WRITE : WAIT;
        data_d  = ld_rvalid ? ld_rdata : data_q;
      end
      WRITE: begin
        state_d = last ? DONE : REQ;
        cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // Address outputs read as zero outside their owning state so reset clears them immediately.
  always_comb begin
    itcm_auto_load = state_q == REQ || state_q == WAIT || state_q == WRITE;
    load_done      = state_q == DONE;
    ld_req         = state_q == REQ;
    ld_addr        = (state_q == REQ) ? SRC_BASE + (ADDR_WIDTH'(cnt_q) << 2) : '0;
    itcm_wr_en     = state_q == WRITE;
    itcm_wr_addr   = (state_q == WRITE) ? ITCM_BASE + (ADDR_WIDTH'(cnt_q) << 2) : '0;
    itcm_wr_data   = (state_q == WRITE) ? data_q : '0;
  end
`ifdef KRV_ITCM_LOAD_CSUM_EN
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic err_q, err_d;
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      acc_q <= '0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      err_q <= err_d;
    end
  end
  // The final word is folded in on the same edge that enters DONE.
  always_comb begin
    acc_d = start ? '0 : (state_q == WRITE) ? acc_q ^ data_q : acc_q;
    err_d = start ? 1'b0 : (state_q == WRITE && last) ? ((acc_q ^ data_q) != exp_csum) : err_q;
  end
  assign load_err = err_q;
`endif
endmodule

// File: tb/tb_itcm_auto_load_ctrl.sv
// tb_itcm_auto_load_ctrl: table-driven and randomized checks of the ITCM auto-load controller
// against a bus responder and a word-list / latency-sum reference model.
module tb_itcm_auto_load_ctrl;
  localparam int LW = 4;
  localparam logic [31:0] SRC = 32'h1000;
  localparam logic [31:0] IBASE = 32'h0;
  logic cpu_clk, cpu_rstn, load_start, itcm_auto_load, load_done, ld_req, ld_ack, ld_rvalid, itcm_wr_en;
  logic [31:0] ld_addr, ld_rdata, itcm_wr_addr, itcm_wr_data;
`ifdef KRV_ITCM_LOAD_CSUM_EN
  logic [31:0] exp_csum;
  logic load_err;
`endif
  itcm_auto_load_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LOAD_WORDS(LW), .SRC_BASE(SRC), .ITCM_BASE(IBASE)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .load_start(load_start),
    .itcm_auto_load(itcm_auto_load), .load_done(load_done),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_ack(ld_ack), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
    .itcm_wr_en(itcm_wr_en), .itcm_wr_addr(itcm_wr_addr), .itcm_wr_data(itcm_wr_data)
`ifdef KRV_ITCM_LOAD_CSUM_EN
    , .exp_csum(exp_csum), .load_err(load_err)
`endif
  );
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;
  typedef struct {
    int ack;
    int rv;
    bit noise;
    logic [31:0] d0;
    int exp_cycles;
  } vec_t;
  vec_t vecs[5];
  int checks = 0, errors = 0;
  int ack_lat[LW], rv_lat[LW];
  logic [31:0] wdata[LW];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_outs_zero(input string name);
    chk(name, {62'd0, |{ld_req, ld_addr, itcm_wr_en, itcm_wr_addr}, |{itcm_wr_data, itcm_auto_load, load_done}}, 64'd0);
  endtask
  // Responder: acks each request after ack_lat cycles, returns data rv_lat cycles after the ack.
  task automatic run_load(input bit noise, input int abort_at, input int exp_cycles);
    int k, j, nwr, cycles;
    bit waiting;
    k = 0; j = 0; nwr = 0; cycles = 0; waiting = 0;
    load_start = 1'b1;
    forever begin
      @(negedge cpu_clk);
      load_start = 1'b0; ld_ack = 1'b0; ld_rvalid = 1'b0; ld_rdata = 32'hDEAD_BEEF;
      if (load_done) break;
      if (noise) load_start = 1'($urandom_range(0, 1));
      cycles++;
      if (cycles > 1000) begin
        checks++; errors++;
        $display("FAIL timeout: load_done not seen after %0d cycles", cycles);
        break;
      end
      chk("auto_load", 64'(itcm_auto_load), 64'd1);
      if (itcm_wr_en) begin
        if (nwr >= LW) begin
          checks++; errors++;
          $display("FAIL extra_write: got write %0d expected at most %0d", nwr + 1, LW);
          break;
        end
        chk("wr_addr", 64'(itcm_wr_addr), 64'(IBASE + 32'(4 * nwr)));
        chk("wr_data", 64'(itcm_wr_data), 64'(wdata[nwr]));
        nwr++; k = 0;
        if (nwr == abort_at) begin
          cpu_rstn = 1'b0; load_start = 1'b0;
          #1;
          chk_outs_zero("abort_outs");
          return;
        end
      end else if (ld_req) begin
        chk("ld_addr", 64'(ld_addr), 64'(SRC + 32'(4 * nwr)));
        if (k == ack_lat[nwr]) begin
          ld_ack = 1'b1;
          if (rv_lat[nwr] == 0) begin
            ld_rvalid = 1'b1; ld_rdata = wdata[nwr];
          end else begin
            waiting = 1; j = 0;
          end
        end else begin
          k++;
          if (noise) ld_rvalid = 1'($urandom_range(0, 1));
        end
      end else if (waiting) begin
        j++;
        if (j == rv_lat[nwr]) begin
          ld_rvalid = 1'b1; ld_rdata = wdata[nwr]; waiting = 0;
        end
      end
    end
    chk("n_writes", 64'(nwr), 64'(LW));
    chk("cycles", 64'(cycles), 64'(exp_cycles));
    chk("done_auto_load", 64'(itcm_auto_load), 64'd0);
    chk("done_flag", 64'(load_done), 64'd1);
  endtask
  initial begin
    int exp, bad;
    cpu_rstn = 1'b0; load_start = 1'b0; ld_ack = 1'b0; ld_rvalid = 1'b0; ld_rdata = '0;
`ifdef KRV_ITCM_LOAD_CSUM_EN
    exp_csum = '0;
`endif
    repeat (2) @(negedge cpu_clk);
    chk_outs_zero("reset_outs");
    cpu_rstn = 1'b1;
    @(negedge cpu_clk);
    vecs[0] = '{1, 0, 1'b0, 32'hA0, 12};
    vecs[1] = '{0, 0, 1'b0, 32'h10, 8};
    vecs[2] = '{5, 0, 1'b1, 32'h55, 28};
    vecs[3] = '{2, 3, 1'b1, 32'h70, 28};
    vecs[4] = '{0, 1, 1'b1, 32'h30, 12};
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < LW; i++) begin
        ack_lat[i] = vecs[v].ack; rv_lat[i] = vecs[v].rv; wdata[i] = vecs[v].d0 + 32'(i);
      end
      run_load(vecs[v].noise, -1, vecs[v].exp_cycles);
    end
    for (int r = 0; r < 20; r++) begin
      exp = 0;
      for (int i = 0; i < LW; i++) begin
        ack_lat[i] = $urandom_range(0, 3); rv_lat[i] = $urandom_range(0, 3); wdata[i] = $urandom;
        exp += ack_lat[i] + rv_lat[i] + 2;
      end
      run_load(1'b1, -1, exp);
    end
    for (int i = 0; i < LW; i++) begin
      ack_lat[i] = 0; rv_lat[i] = 0; wdata[i] = 32'hB0 + 32'(i);
    end
    run_load(1'b0, 2, 0);
    repeat (2) @(negedge cpu_clk);
    chk_outs_zero("held_reset_outs");
    cpu_rstn = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge cpu_clk);
      if (itcm_wr_en || ld_req || load_done || itcm_auto_load) bad++;
    end
    chk("idle_after_reset", 64'(bad), 64'd0);
    run_load(1'b0, -1, 8);
`ifdef KRV_ITCM_LOAD_CSUM_EN
    for (int i = 0; i < LW; i++) begin
      ack_lat[i] = 1; rv_lat[i] = 0; wdata[i] = 32'(1) << i;
    end
    exp_csum = 32'hF;
    run_load(1'b0, -1, 12);
    chk("csum_ok", 64'(load_err), 64'd0);
    exp_csum = 32'hE;
    run_load(1'b0, -1, 12);
    chk("csum_bad", 64'(load_err), 64'd1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
